// File: rtl/dcache_fill.sv
// Data-cache miss refill engine: victim select, dirty writeback handoff, 8-beat line fetch, single-cycle tag/data commit.
// Optional DCACHE_FILL_INVALID_FIRST_EN: prefer the lowest invalid way over the round-robin victim.
module dcache_fill #(
    parameter int LINE_BEATS = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     lookup2fill_valid,
    output logic                     fill2lookup_ready,
    input  logic [53:0]              lookup2fill_addr,
    input  logic                     lookup2fill_store,
    input  logic [7:0]               lookup2fill_valid_ways,
    input  logic [7:0]               lookup2fill_dirty_ways,
    input  logic                     lookup2fill_busy,
    output logic                     fill2lookup_done,
    output logic                     fill2wb_valid,
    input  logic                     wb2fill_ready,
    output logic [5:0]               fill2wb_index,
    output logic [2:0]               fill2wb_way,
    output logic                     fill2mem_req_valid,
    input  logic                     mem2fill_req_ready,
    output logic [53:0]              fill2mem_req_addr,
    input  logic                     mem2fill_resp_valid,
    input  logic [63:0]              mem2fill_resp_data,
    output logic                     fill2tag_array_valid,
    output logic [5:0]               fill2tag_array_index,
    output logic [2:0]               fill2tag_array_way,
    output logic [43:0]              fill2tag_array_wdata,
    output logic                     fill2data_array_valid,
    output logic [5:0]               fill2data_array_index,
    output logic [2:0]               fill2data_array_way,
    output logic [LINE_BEATS*64-1:0] fill2data_array_wdata
);
    localparam int BEAT_W = $clog2(LINE_BEATS);

    typedef enum logic [2:0] {S_IDLE, S_WB, S_MREQ, S_RECV, S_WRITE, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic [2:0]              rr_q, rr_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [53:6]             addr_q, addr_d;
    logic                    store_q, store_d;
    logic [2:0]              way_q, way_d;
    logic                    use_rr_q, use_rr_d;
    logic [LINE_BEATS*64-1:0] line_q, line_d;

    logic [2:0] victim;
    logic       victim_rr;
    logic       wb_v, req_v, wr_v, done_v, unused_bits;

    always_comb begin
        victim    = rr_q;
        victim_rr = 1'b1;
`ifdef DCACHE_FILL_INVALID_FIRST_EN
        // Descending scan so the lowest invalid way wins.
        for (int i = 7; i >= 0; i--) begin
            if (!lookup2fill_valid_ways[i]) begin
                victim    = 3'(i);
                victim_rr = 1'b0;
            end
        end
`endif
    end

`ifdef DCACHE_FILL_INVALID_FIRST_EN
    assign unused_bits = ^lookup2fill_addr[5:0];
`else
    assign unused_bits = ^{lookup2fill_addr[5:0], lookup2fill_valid_ways};
`endif

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        store_d  = store_q;
        way_d    = way_q;
        use_rr_d = use_rr_q;
        line_d   = line_q;
        wb_v     = 1'b0;
        req_v    = 1'b0;
        wr_v     = 1'b0;
        done_v   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (lookup2fill_valid) begin
                    addr_d   = lookup2fill_addr[53:6];
                    store_d  = lookup2fill_store;
                    way_d    = victim;
                    use_rr_d = victim_rr;
                    state_d  = (lookup2fill_dirty_ways[victim] && lookup2fill_valid_ways[victim])
                               ? S_WB : S_MREQ;
                end
            end
            S_WB: begin
                wb_v = 1'b1;
                if (wb2fill_ready) state_d = S_MREQ;
            end
            S_MREQ: begin
                req_v = 1'b1;
                if (mem2fill_req_ready) begin
                    state_d = S_RECV;
                    beat_d  = '0;
                end
            end
            S_RECV: begin
                if (mem2fill_resp_valid) begin
                    line_d[{beat_q, 6'b0} +: 64] = mem2fill_resp_data;
                    beat_d = beat_q + 1'b1;
                    if (beat_q == BEAT_W'(LINE_BEATS - 1)) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Lookup owns the array ports whenever it is busy; defer the commit.
                if (!lookup2fill_busy) begin
                    wr_v    = 1'b1;
                    rr_d    = rr_q + 3'(use_rr_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_v  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    always_ff @(posedge clock) begin
        addr_q   <= addr_d;
        store_q  <= store_d;
        way_q    <= way_d;
        use_rr_q <= use_rr_d;
        line_q   <= line_d;
    end

    // Every handshake output is masked while reset is held so an aborted fill never leaks a write.
    assign fill2lookup_ready     = reset && (state_q == S_IDLE);
    assign fill2wb_valid         = reset && wb_v;
    assign fill2mem_req_valid    = reset && req_v;
    assign fill2tag_array_valid  = reset && wr_v;
    assign fill2data_array_valid = reset && wr_v;
    assign fill2lookup_done      = reset && done_v;

    assign fill2wb_index         = addr_q[11:6];
    assign fill2wb_way           = way_q;
    assign fill2mem_req_addr     = {addr_q, 6'b0};
    assign fill2tag_array_index  = addr_q[11:6];
    assign fill2tag_array_way    = way_q;
    assign fill2tag_array_wdata  = {1'b1, store_q, addr_q[53:12]};
    assign fill2data_array_index = addr_q[11:6];
    assign fill2data_array_way   = way_q;
    assign fill2data_array_wdata = line_q;
endmodule

// File: tb/tb_dcache_fill.sv
// Randomized + directed bench for dcache_fill against a handshake-level transaction model.
module tb_dcache_fill;
    logic         clock = 0, reset = 0;
    logic         lookup2fill_valid = 0, lookup2fill_store = 0, lookup2fill_busy = 0;
    logic [53:0]  lookup2fill_addr = '0;
    logic [7:0]   lookup2fill_valid_ways = '0, lookup2fill_dirty_ways = '0;
    logic         wb2fill_ready = 0, mem2fill_req_ready = 0, mem2fill_resp_valid = 0;
    logic [63:0]  mem2fill_resp_data = '0;
    logic         fill2lookup_ready, fill2lookup_done, fill2wb_valid, fill2mem_req_valid;
    logic [5:0]   fill2wb_index, fill2tag_array_index, fill2data_array_index;
    logic [2:0]   fill2wb_way, fill2tag_array_way, fill2data_array_way;
    logic [53:0]  fill2mem_req_addr;
    logic         fill2tag_array_valid, fill2data_array_valid;
    logic [43:0]  fill2tag_array_wdata;
    logic [511:0] fill2data_array_wdata;

    dcache_fill #(.LINE_BEATS(8)) dut (
        .clock(clock), .reset(reset),
        .lookup2fill_valid(lookup2fill_valid), .fill2lookup_ready(fill2lookup_ready),
        .lookup2fill_addr(lookup2fill_addr), .lookup2fill_store(lookup2fill_store),
        .lookup2fill_valid_ways(lookup2fill_valid_ways), .lookup2fill_dirty_ways(lookup2fill_dirty_ways),
        .lookup2fill_busy(lookup2fill_busy), .fill2lookup_done(fill2lookup_done),
        .fill2wb_valid(fill2wb_valid), .wb2fill_ready(wb2fill_ready),
        .fill2wb_index(fill2wb_index), .fill2wb_way(fill2wb_way),
        .fill2mem_req_valid(fill2mem_req_valid), .mem2fill_req_ready(mem2fill_req_ready),
        .fill2mem_req_addr(fill2mem_req_addr),
        .mem2fill_resp_valid(mem2fill_resp_valid), .mem2fill_resp_data(mem2fill_resp_data),
        .fill2tag_array_valid(fill2tag_array_valid), .fill2tag_array_index(fill2tag_array_index),
        .fill2tag_array_way(fill2tag_array_way), .fill2tag_array_wdata(fill2tag_array_wdata),
        .fill2data_array_valid(fill2data_array_valid), .fill2data_array_index(fill2data_array_index),
        .fill2data_array_way(fill2data_array_way), .fill2data_array_wdata(fill2data_array_wdata)
    );

    always #5 clock = ~clock;

    int n_tests = 0, n_fail = 0;

    function automatic void chk(string nm, logic [511:0] act, logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Responder knobs
    int wb_delay = 1, busy_hold = 0;
    bit rnd = 0, fixed_data = 1;

    // Transaction model: one outstanding miss, tracked by which handshakes have happened.
    bit           out_q = 0, m_dirty, m_use_rr, wb_done, req_done, wrote;
    int           nbeats, m_way, m_rr = 0, cyc = 0, acc_cyc, last_lat, wb_cycles, last_wb_cycles;
    int           last_wb_way, last_way, n_writes = 0, n_dones = 0;
    logic [53:0]  m_addr, last_req_addr;
    bit           m_store;
    logic [511:0] m_line;
    logic [43:0]  last_tag;
    logic [5:0]   last_idx;
    logic [63:0]  last_word3;
    int           way_log[$];

    always @(negedge clock) begin
        bit exp_ready, exp_wb, exp_req, exp_wr, exp_done;
        cyc++;
        if (!reset) begin
            chk("rst_ready", 512'(fill2lookup_ready), 512'(0));
            chk("rst_valids", 512'({fill2wb_valid, fill2mem_req_valid, fill2tag_array_valid,
                                    fill2data_array_valid, fill2lookup_done}), 512'(0));
            out_q = 0;
            m_rr  = 0;
        end else begin
            exp_ready = !out_q;
            exp_wb    = out_q && m_dirty && !wb_done;
            exp_req   = out_q && (!m_dirty || wb_done) && !req_done;
            exp_wr    = out_q && nbeats == 8 && !wrote && !lookup2fill_busy;
            exp_done  = out_q && wrote;
            chk("ready", 512'(fill2lookup_ready), 512'(exp_ready));
            chk("wb_valid", 512'(fill2wb_valid), 512'(exp_wb));
            chk("req_valid", 512'(fill2mem_req_valid), 512'(exp_req));
            chk("tag_valid", 512'(fill2tag_array_valid), 512'(exp_wr));
            chk("data_valid", 512'(fill2data_array_valid), 512'(exp_wr));
            chk("done", 512'(fill2lookup_done), 512'(exp_done));
            if (exp_wb && fill2wb_valid) begin
                chk("wb_index", 512'(fill2wb_index), 512'(m_addr[11:6]));
                chk("wb_way", 512'(fill2wb_way), 512'(m_way));
                last_wb_way = fill2wb_way;
            end
            if (exp_req && fill2mem_req_valid) begin
                chk("req_addr", 512'(fill2mem_req_addr), 512'({m_addr[53:6], 6'b0}));
                last_req_addr = fill2mem_req_addr;
            end
            if (exp_wr && fill2tag_array_valid) begin
                chk("tag_index", 512'(fill2tag_array_index), 512'(m_addr[11:6]));
                chk("tag_way", 512'(fill2tag_array_way), 512'(m_way));
                chk("tag_wdata", 512'(fill2tag_array_wdata), 512'({1'b1, m_store, m_addr[53:12]}));
                chk("data_index", 512'(fill2data_array_index), 512'(m_addr[11:6]));
                chk("data_way", 512'(fill2data_array_way), 512'(m_way));
                chk("data_wdata", fill2data_array_wdata, m_line);
                last_tag = fill2tag_array_wdata; last_idx = fill2tag_array_index;
                last_way = fill2tag_array_way;   last_word3 = fill2data_array_wdata[255:192];
            end
            if (fill2tag_array_valid) n_writes++;
            if (fill2lookup_done) n_dones++;
            // Model advances with the handshakes the coming edge will complete.
            if (exp_done) begin
                out_q = 0;
                last_lat = cyc - acc_cyc;
            end else if (exp_wr) begin
                wrote = 1;
                if (m_use_rr) m_rr = (m_rr + 1) % 8;
                way_log.push_back(m_way);
            end
            if (out_q && req_done && nbeats < 8 && mem2fill_resp_valid) begin
                m_line[nbeats*64 +: 64] = mem2fill_resp_data;
                nbeats++;
            end
            if (exp_wb) begin
                wb_cycles++;
                if (wb2fill_ready) begin wb_done = 1; last_wb_cycles = wb_cycles; end
            end
            if (exp_req && mem2fill_req_ready) req_done = 1;
            if (exp_ready && lookup2fill_valid) begin
                out_q = 1; acc_cyc = cyc; m_addr = lookup2fill_addr; m_store = lookup2fill_store;
                wb_done = 0; req_done = 0; wrote = 0; nbeats = 0; wb_cycles = 0;
                m_way = m_rr; m_use_rr = 1;
`ifdef DCACHE_FILL_INVALID_FIRST_EN
                for (int i = 7; i >= 0; i--)
                    if (!lookup2fill_valid_ways[i]) begin m_way = i; m_use_rr = 0; end
`endif
                m_dirty = lookup2fill_valid_ways[m_way] && lookup2fill_dirty_ways[m_way];
            end
        end
    end

    // Writeback unit, memory and lookup-busy responders.
    int beats_left = 0, beat_no = 0, busy_cnt = 0, wb_cnt = 0;
    bit last_beat = 0;
    always begin
        bit hs_req, wbv, wbhs;
        @(posedge clock);
        hs_req = fill2mem_req_valid && mem2fill_req_ready;
        wbv    = fill2wb_valid;
        wbhs   = fill2wb_valid && wb2fill_ready;
        #1;
        if (wbhs) wb_cnt = 0; else if (wbv) wb_cnt++;
        wb2fill_ready = (wb_cnt >= wb_delay - 1);
        mem2fill_req_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (hs_req) begin beats_left = 8; beat_no = 0; end
        if (last_beat) busy_cnt = busy_hold;
        last_beat = 0;
        if (beats_left > 0 && (!rnd || $urandom_range(0, 2) != 0)) begin
            mem2fill_resp_valid = 1;
            mem2fill_resp_data  = fixed_data ? 64'(17 * (beat_no + 1)) : {$urandom, $urandom};
            beat_no++; beats_left--;
            if (beats_left == 0) last_beat = 1;
        end else begin
            mem2fill_resp_valid = 0;
            mem2fill_resp_data  = {$urandom, $urandom};
        end
        if (busy_cnt > 0) begin lookup2fill_busy = 1; busy_cnt--; end
        else lookup2fill_busy = rnd ? ($urandom_range(0, 4) == 0) : 1'b0;
    end

    task automatic present(input logic [53:0] a, input bit st, input logic [7:0] vw, input logic [7:0] dw);
        bit acc = 0;
        lookup2fill_valid = 1; lookup2fill_addr = a; lookup2fill_store = st;
        lookup2fill_valid_ways = vw; lookup2fill_dirty_ways = dw;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(posedge clock);
            acc = fill2lookup_ready && lookup2fill_valid;
            #1;
        end
        lookup2fill_valid = 0;
        if (!acc) chk("accept_timeout", 512'(0), 512'(1));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && out_q; i++) @(negedge clock);
        if (out_q) chk("idle_timeout", 512'(out_q), 512'(0));
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1;
    endtask

    initial begin
        int w0, d0;
        repeat (3) @(posedge clock);
        #1 reset = 1;

        // Clean miss, fixed beats 0x11..0x88
        present(54'h1040, 0, 8'hFF, 8'h00);
        wait_idle();
        chk("t1_latency", 512'(last_lat), 512'(11));
        chk("t1_req_addr", 512'(last_req_addr), 512'(54'h1040));
        chk("t1_way", 512'(last_way), 512'(0));
        chk("t1_index", 512'(last_idx), 512'(1));
        chk("t1_tag_wdata", 512'(last_tag), 512'(44'h80000000001));
        chk("t1_beat3", 512'(last_word3), 512'(64'h44));

        // Dirty victim, writeback ready after 5 cycles
        do_reset();
        wb_delay = 5;
        present(54'h3_0000_2040, 1, 8'hFF, 8'h01);
        wait_idle();
        chk("t2_wb_cycles", 512'(last_wb_cycles), 512'(5));
        chk("t2_wb_way", 512'(last_wb_way), 512'(0));
        chk("t2_latency", 512'(last_lat), 512'(16));
        wb_delay = 1;

        // Lookup busy for 3 cycles at WRITE
        busy_hold = 3;
        present(54'h0_0000_5FC0, 0, 8'hFF, 8'h00);
        wait_idle();
        chk("t3_latency", 512'(last_lat), 512'(14));
        busy_hold = 0;

        // Nine back-to-back fills: rr walks 0..7 and wraps
        do_reset();
        way_log.delete();
        for (int i = 0; i < 9; i++) present({$urandom, $urandom} & 54'h3F_FFFF_FFFF_FFC0, 1'($urandom), 8'hFF, 8'h00);
        wait_idle();
        chk("t4_count", 512'(way_log.size()), 512'(9));
        for (int i = 0; i < 9 && i < way_log.size(); i++) chk("t4_rr_way", 512'(way_log[i]), 512'(i % 8));

        // Reset in the middle of RECV
        do_reset();
        w0 = n_writes; d0 = n_dones;
        present(54'h7_7777_7780, 0, 8'hFF, 8'h00);
        for (int i = 0; i < 100 && !(out_q && nbeats == 4); i++) @(negedge clock);
        chk("t5_reached_beat4", 512'(nbeats), 512'(4));
        do_reset();
        repeat (12) @(posedge clock);
        #1;
        chk("t5_no_write", 512'(n_writes), 512'(w0));
        chk("t5_no_done", 512'(n_dones), 512'(d0));
        present(54'h1_2345_6780, 1, 8'hFF, 8'h00);
        wait_idle();
        chk("t5_after_way", 512'(last_way), 512'(0));

        // Invalid-first victim choice
        do_reset();
        way_log.delete();
        present(54'h2_0000_0100, 0, 8'hF3, 8'hFF);
        wait_idle();
        present(54'h2_0000_0140, 0, 8'hFF, 8'h00);
        wait_idle();
`ifdef DCACHE_FILL_INVALID_FIRST_EN
        chk("t6_way_f3", 512'(way_log[0]), 512'(2));
        chk("t6_way_ff", 512'(way_log[1]), 512'(0));
`else
        chk("t6_way_f3", 512'(way_log[0]), 512'(0));
        chk("t6_way_ff", 512'(way_log[1]), 512'(1));
`endif

        // Randomized traffic
        rnd = 1; fixed_data = 0;
        for (int i = 0; i < 40; i++) begin
            wb_delay = $urandom_range(1, 4);
            present({$urandom, $urandom}, 1'($urandom), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 1) wait_idle();
        end
        wait_idle();
        rnd = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
